fifo_rd_packer: RTL

- Sits directly downstream of the 16-deep, 8-bit sync FIFO, on its read side.
- Pops bytes whenever the FIFO is non-empty and packs PACK consecutive bytes into one wide word.
- Presents each packed word on a valid/ready output stream to the next consumer.
- Isolates FIFO pop timing from downstream backpressure without losing or duplicating bytes.

---
 rtl/fifo_rd_packer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side byte packer for the 16x8 sync FIFO: pops bytes, packs PACK of them per word,
// and emits words on a valid/ready stream. Optional partial-word flush: define PACK_TIMEOUT_EN.
module fifo_rd_packer #(
  parameter int W_DATA  = 8,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fifo_empty,
  output logic                     fifo_pop,
  input  logic [W_DATA-1:0]        fifo_rdata,
  output logic [W_DATA*PACK-1:0]   out_data,
  output logic [PACK-1:0]          out_keep,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int CW = $clog2(PACK + 1);
  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  // Same encoding as the FIFO's pop request type.
  typedef enum logic {NO_POP = 1'b0, POP = 1'b1} pop_e_t;

  logic [W_DATA*PACK-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   inflight_q, inflight_d;
  logic [W_DATA*PACK-1:0] out_data_q, out_data_d;
  logic [PACK-1:0]        out_keep_q, out_keep_d;
  logic                   out_valid_q, out_valid_d;

  logic                   hold;
  logic                   out_free;
  logic                   xfer;
  logic                   room;
  logic [CW:0]            fill;
  logic                   partial;
  pop_e_t                 pop_sel;

  assign hold     = (cnt_q == PACK_C);
  assign out_free = !out_valid_q || out_ready;
  assign xfer     = hold && out_free;
  assign fill     = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
  assign room     = (fill < (CW+1)'(PACK));

`ifdef PACK_TIMEOUT_EN
  logic [7:0] idle_q, idle_d;
  logic       idle_cond;

  assign idle_cond = (cnt_q != '0) && !hold && !inflight_q && fifo_empty;
  assign partial   = (idle_q == 8'(TIMEOUT)) && out_free;

  // Saturate so a flush blocked by backpressure still fires once the output frees up.
  always_comb begin
    idle_d = 8'd0;
    if (idle_cond && !partial) begin
      if (idle_q == 8'(TIMEOUT)) idle_d = idle_q;
      else                       idle_d = idle_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= 8'd0;
    else        idle_q <= idle_d;
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign partial        = 1'b0;
`endif

  always_comb begin
    pop_sel = NO_POP;
    if (rst_n && !fifo_empty && !partial && (xfer || room)) pop_sel = POP;
  end

  assign fifo_pop   = (pop_sel == POP);
  assign inflight_d = fifo_pop;

  // Accumulator: clear on a word leaving, then land the returning byte in lane cnt.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (xfer || partial) begin
      acc_d = '0;
      cnt_d = '0;
    end
    if (inflight_q) begin
      for (int i = 0; i < PACK; i++) begin
        if (cnt_q == CW'(i)) acc_d[i*W_DATA +: W_DATA] = fifo_rdata;
      end
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = acc_q;
      out_keep_d  = {PACK{1'b1}};
      out_valid_d = 1'b1;
    end else if (partial) begin
      for (int i = 0; i < PACK; i++) begin
        out_keep_d[i]                  = (CW'(i) < cnt_q);
        out_data_d[i*W_DATA +: W_DATA] = (CW'(i) < cnt_q) ? acc_q[i*W_DATA +: W_DATA] : '0;
      end
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_valid = out_valid_q;

endmodule
